// File: rtl/pe_flit_injector_if.sv
// PE-to-router injection port bundle: PE send side, router output side,
// credit return path and FIFO status.
interface pe_flit_injector_if #(
   parameter int FLIT_W = 71,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [FLIT_W-1:0] pe_flit_in;
   logic              pe_ready_send;
   logic [FLIT_W-1:0] router_flit_out;
   logic              router_valid;
   logic              credit_return;
   logic              credit_vc;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              overflow_err;

   // environment side: drives PE flits and router credits
   modport master (
      output pe_flit_in, pe_ready_send, credit_return, credit_vc,
      input  router_flit_out, router_valid, fifo_count, fifo_full, overflow_err
   );

   // injector side
   modport slave (
      input  pe_flit_in, pe_ready_send, credit_return, credit_vc,
      output router_flit_out, router_valid, fifo_count, fifo_full, overflow_err
   );
endinterface

// File: rtl/pe_flit_injector.sv
// PE flit injector: buffers PE result flits in a small FIFO and injects them
// in order into the local router port under per-VC credit flow control.
//
// state   | meaning
// --------+-----------------------------------------------------------
// EMPTY   | FIFO holds no flits
// READY   | head flit present and its VC has at least one credit
// BLOCKED | head flit present but its VC has no credit (stalls all VCs)
module pe_flit_injector #(
   parameter int FLIT_W  = 71,
   parameter int DEPTH   = 4,
   parameter int CREDITS = 4,
   parameter int VC_BIT  = 64
) (
   input logic               clk,
   input logic               reset,
   pe_flit_injector_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int CR_W  = $clog2(CREDITS + 1);

   typedef enum logic [1:0] {EMPTY, READY, BLOCKED} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [FLIT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr_nxt;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_nxt;
   logic [CR_W-1:0]   credit     [2];
   logic [CR_W-1:0]   credit_nxt [2];
   logic              head_vc;
   logic              nxt_head_vc;
   logic              push_req;
   logic              pop;
   logic              accept;
   logic              drop;
   logic              pop_v;
   logic              ret_v;

   // push/pop decisions, credit bookkeeping and next head-state evaluation
   always_comb begin
      head_vc  = mem[rd_ptr][VC_BIT];
      push_req = bus.pe_ready_send && bus.pe_flit_in[FLIT_W-1];
      pop      = (state != EMPTY) && (credit[head_vc] != '0);
      // a full FIFO can still take a flit when the head leaves in the same cycle
      accept   = push_req && ((count != CNT_W'(DEPTH)) || pop);
      drop     = push_req && !accept;

      pop_v = 1'b0;
      ret_v = 1'b0;
      for (int v = 0; v < 2; v++) begin
         credit_nxt[v] = credit[v];
         pop_v = pop && (head_vc == 1'(v));
         ret_v = bus.credit_return && (bus.credit_vc == 1'(v));
         if (pop_v && !ret_v)
            credit_nxt[v] = credit[v] - CR_W'(1);
         else if (ret_v && !pop_v && (credit[v] != CR_W'(CREDITS)))
            credit_nxt[v] = credit[v] + CR_W'(1);
      end

      count_nxt  = count + CNT_W'(accept) - CNT_W'(pop);
      rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

      // when the FIFO drains to nothing this cycle, the incoming flit becomes the head
      if ((pop && (count == CNT_W'(1))) || (!pop && (count == '0)))
         nxt_head_vc = bus.pe_flit_in[VC_BIT];
      else
         nxt_head_vc = mem[rd_ptr_nxt][VC_BIT];

      if (count_nxt == '0)
         state_nxt = EMPTY;
      else if (credit_nxt[nxt_head_vc] == '0)
         state_nxt = BLOCKED;
      else
         state_nxt = READY;
   end

   // FIFO storage, pointers, credits, head state and registered router outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state               <= EMPTY;
         rd_ptr              <= '0;
         wr_ptr              <= '0;
         count               <= '0;
         credit[0]           <= CR_W'(CREDITS);
         credit[1]           <= CR_W'(CREDITS);
         bus.router_flit_out <= '0;
         bus.router_valid    <= 1'b0;
         bus.fifo_count      <= '0;
         bus.fifo_full       <= 1'b0;
         bus.overflow_err    <= 1'b0;
      end else begin
         if (accept) begin
            mem[wr_ptr] <= bus.pe_flit_in;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop)
            bus.router_flit_out <= mem[rd_ptr];
         bus.router_valid <= pop;
         rd_ptr           <= rd_ptr_nxt;
         count            <= count_nxt;
         credit[0]        <= credit_nxt[0];
         credit[1]        <= credit_nxt[1];
         state            <= state_nxt;
         bus.fifo_count   <= count_nxt;
         bus.fifo_full    <= (count_nxt == CNT_W'(DEPTH));
         if (drop)
            bus.overflow_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_pe_flit_injector.sv
// Bench for pe_flit_injector: directed vector table, random traffic against a
// queue-based reference model, and a push-to-inject latency check.
module tb_pe_flit_injector;
   localparam int FLIT_W  = 71;
   localparam int DEPTH   = 4;
   localparam int CREDITS = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   pe_flit_injector_if #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) bus ();

   pe_flit_injector #(
      .FLIT_W (FLIT_W),
      .DEPTH  (DEPTH),
      .CREDITS(CREDITS),
      .VC_BIT (64)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // reference model: queue of buffered flits, credit counters, sticky error
   logic [70:0] mq[$];
   int          mcr[2];
   bit          merr;
   bit          mvalid;
   logic [70:0] mout;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_edge();
      int  sz;
      int  v;
      bit  do_pop;
      bit  push;
      if (reset) begin
         mq.delete();
         mcr[0] = CREDITS;
         mcr[1] = CREDITS;
         merr   = 1'b0;
         mvalid = 1'b0;
         mout   = '0;
      end else begin
         sz     = mq.size();
         do_pop = (sz > 0) && (mcr[mq[0][64]] > 0);
         push   = bus.pe_ready_send && bus.pe_flit_in[70];
         mvalid = do_pop;
         if (do_pop) begin
            v    = int'(mq[0][64]);
            mout = mq[0];
            void'(mq.pop_front());
            mcr[v] = mcr[v] - 1;
         end
         if (bus.credit_return) begin
            v = int'(bus.credit_vc);
            mcr[v] = (mcr[v] + 1 > CREDITS) ? CREDITS : mcr[v] + 1;
         end
         if (push) begin
            if (sz < DEPTH || do_pop) mq.push_back(bus.pe_flit_in);
            else                      merr = 1'b1;
         end
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      chk("router_valid", 128'(bus.router_valid), 128'(mvalid));
      chk("router_flit_out", 128'(bus.router_flit_out), 128'(mout));
      chk("fifo_count", 128'(bus.fifo_count), 128'(mq.size()));
      chk("fifo_full", 128'(bus.fifo_full), 128'(mq.size() == DEPTH));
      chk("overflow_err", 128'(bus.overflow_err), 128'(merr));
   endtask

   function automatic logic [70:0] mk(input bit vc, input logic [3:0] dest, input logic [63:0] pl);
      return {1'b1, 1'b1, dest, vc, pl};
   endfunction

   typedef struct {
      bit          rst;
      bit          send;
      logic [70:0] flit;
      bit          cret;
      bit          cvc;
      bit          ev;
      logic [70:0] eo;
      int          ec;
      bit          ef;
      bit          ee;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input bit rst, input bit send, input logic [70:0] flit,
                               input bit cret, input bit cvc, input bit ev,
                               input logic [70:0] eo, input int ec, input bit ef, input bit ee);
      vec_t r;
      r.rst = rst; r.send = send; r.flit = flit; r.cret = cret; r.cvc = cvc;
      r.ev = ev; r.eo = eo; r.ec = ec; r.ef = ef; r.ee = ee;
      tbl.push_back(r);
   endfunction

   initial begin
      logic [70:0] f2;
      logic [70:0] nv;
      logic [70:0] z;
      logic [70:0] af[5];
      logic [70:0] bf[2];
      logic [70:0] cf[6];
      logic [70:0] df[3];
      logic [70:0] ef0;
      logic [95:0] rnd;
      int          lat;
      bit          seen;

      bus.pe_flit_in    = '0;
      bus.pe_ready_send = 1'b0;
      bus.credit_return = 1'b0;
      bus.credit_vc     = 1'b0;

      z  = '0;
      f2 = {1'b1, 1'b1, 4'b0110, 1'b0, 64'hF0F0_F0F0_0F0F_0F0F};
      nv = mk(1'b0, 4'h3, 64'hDEAD_BEEF);
      nv[70] = 1'b0;
      for (int i = 0; i < 5; i++) af[i] = mk(1'b0, 4'(i + 1), 64'hA000 + 64'(i));
      bf[0] = mk(1'b0, 4'h2, 64'hB000);
      bf[1] = mk(1'b1, 4'h5, 64'hB001);
      for (int i = 0; i < 6; i++) cf[i] = mk(1'b0, 4'(i + 8), 64'hC000 + 64'(i));
      for (int i = 0; i < 3; i++) df[i] = mk(1'b0, 4'(i), 64'hD000 + 64'(i));
      ef0 = mk(1'b0, 4'hE, 64'hE000);

      // reset, then single flit with one-cycle latency
      add(1, 0, z, 0, 0,   0, z, 0, 0, 0);
      add(1, 0, z, 0, 0,   0, z, 0, 0, 0);
      add(0, 0, z, 0, 0,   0, z, 0, 0, 0);
      add(0, 1, f2, 0, 0,  0, z, 1, 0, 0);
      add(0, 0, z, 0, 0,   1, f2, 0, 0, 0);
      add(0, 0, z, 1, 0,   0, z, 0, 0, 0);
      // five VC0 flits back-to-back, fifth waits for a credit
      add(0, 1, af[0], 0, 0, 0, z, 1, 0, 0);
      add(0, 1, af[1], 0, 0, 1, af[0], 1, 0, 0);
      add(0, 1, af[2], 0, 0, 1, af[1], 1, 0, 0);
      add(0, 1, af[3], 0, 0, 1, af[2], 1, 0, 0);
      add(0, 1, af[4], 0, 0, 1, af[3], 1, 0, 0);
      add(0, 0, z, 0, 0,   0, z, 1, 0, 0);
      add(0, 0, z, 0, 0,   0, z, 1, 0, 0);
      add(0, 0, z, 1, 0,   0, z, 1, 0, 0);
      add(0, 0, z, 0, 0,   1, af[4], 0, 0, 0);
      // head-of-line: VC0 head blocks VC1 flit; VC1 return does not unblock
      add(0, 1, bf[0], 0, 0, 0, z, 1, 0, 0);
      add(0, 1, bf[1], 0, 0, 0, z, 2, 0, 0);
      add(0, 0, z, 1, 1,   0, z, 2, 0, 0);
      add(0, 0, z, 0, 0,   0, z, 2, 0, 0);
      add(0, 0, z, 1, 0,   0, z, 2, 0, 0);
      add(0, 0, z, 0, 0,   1, bf[0], 1, 0, 0);
      add(0, 0, z, 0, 0,   1, bf[1], 0, 0, 0);
      // overflow while blocked, push-at-full with pop, drain with sticky error
      add(0, 1, cf[0], 0, 0, 0, z, 1, 0, 0);
      add(0, 1, cf[1], 0, 0, 0, z, 2, 0, 0);
      add(0, 1, cf[2], 0, 0, 0, z, 3, 0, 0);
      add(0, 1, cf[3], 0, 0, 0, z, 4, 1, 0);
      add(0, 1, cf[4], 0, 0, 0, z, 4, 1, 1);
      add(0, 1, nv, 0, 0,    0, z, 4, 1, 1);
      add(0, 0, z, 1, 0,     0, z, 4, 1, 1);
      add(0, 1, cf[5], 0, 0, 1, cf[0], 4, 1, 1);
      add(0, 0, z, 1, 0,     0, z, 4, 1, 1);
      add(0, 0, z, 1, 0,     1, cf[1], 3, 0, 1);
      add(0, 0, z, 1, 0,     1, cf[2], 2, 0, 1);
      add(0, 0, z, 1, 0,     1, cf[3], 1, 0, 1);
      add(0, 0, z, 0, 0,     1, cf[5], 0, 0, 1);
      add(0, 0, z, 0, 0,     0, z, 0, 0, 1);
      // reset with three flits buffered
      add(0, 1, df[0], 0, 0, 0, z, 1, 0, 1);
      add(0, 1, df[1], 0, 0, 0, z, 2, 0, 1);
      add(0, 1, df[2], 0, 0, 0, z, 3, 0, 1);
      add(1, 1, af[0], 1, 0, 0, z, 0, 0, 0);
      add(0, 0, z, 0, 0,     0, z, 0, 0, 0);
      add(0, 1, ef0, 0, 0,   0, z, 1, 0, 0);
      add(0, 0, z, 0, 0,     1, ef0, 0, 0, 0);

      foreach (tbl[i]) begin
         reset             = tbl[i].rst;
         bus.pe_ready_send = tbl[i].send;
         bus.pe_flit_in    = tbl[i].flit;
         bus.credit_return = tbl[i].cret;
         bus.credit_vc     = tbl[i].cvc;
         step();
         chk($sformatf("vec%0d valid", i), 128'(bus.router_valid), 128'(tbl[i].ev));
         if (tbl[i].ev)
            chk($sformatf("vec%0d flit", i), 128'(bus.router_flit_out), 128'(tbl[i].eo));
         chk($sformatf("vec%0d count", i), 128'(bus.fifo_count), 128'(tbl[i].ec));
         chk($sformatf("vec%0d full", i), 128'(bus.fifo_full), 128'(tbl[i].ef));
         chk($sformatf("vec%0d err", i), 128'(bus.overflow_err), 128'(tbl[i].ee));
      end

      // random traffic with varying credit-return pressure
      reset = 1'b1;
      bus.pe_ready_send = 1'b0;
      bus.credit_return = 1'b0;
      step();
      step();
      for (int c = 0; c < 3200; c++) begin
         reset             = ($urandom_range(0, 199) == 0);
         bus.pe_ready_send = 1'($urandom_range(0, 1));
         rnd               = {$urandom, $urandom, $urandom};
         bus.pe_flit_in    = rnd[70:0];
         bus.pe_flit_in[70] = ($urandom_range(0, 9) != 0);
         bus.credit_return = ($urandom_range(0, 3) < ((c / 400) % 4));
         bus.credit_vc     = 1'($urandom_range(0, 1));
         step();
      end

      // push-to-inject latency after a fresh reset
      reset = 1'b1;
      bus.pe_ready_send = 1'b0;
      bus.credit_return = 1'b0;
      step();
      step();
      reset = 1'b0;
      bus.pe_ready_send = 1'b1;
      bus.pe_flit_in    = f2;
      step();
      bus.pe_ready_send = 1'b0;
      lat  = 0;
      seen = 1'b0;
      for (int k = 1; k <= 8 && !seen; k++) begin
         step();
         if (bus.router_valid) begin
            seen = 1'b1;
            lat  = k;
         end
      end
      chk("latency", 128'(lat), 128'(1));
      chk("latency flit", 128'(bus.router_flit_out), 128'(f2));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
